// File: rtl/regfile_mp_scoreboard.sv
// Multi-read-port integer register file with hardwired-zero x0, optional write-to-read
// bypass and a per-register busy scoreboard so decode can stall on pending writes.
module regfile_mp_scoreboard #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   r_addr,
    output logic [NRD*XLEN-1:0] r_data,
    output logic [NRD-1:0]      r_busy,
    input  logic                w_en,
    input  logic [AW-1:0]       w_addr,
    input  logic [XLEN-1:0]     w_data,
    input  logic                sb_set_en,
    input  logic [AW-1:0]       sb_set_addr
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic            w_live;

    assign w_live = w_en && (w_addr != '0);

    // Set is applied after clear so a newly issued producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (w_live) begin
            busy_d[w_addr] = 1'b0;
        end
        if (sb_set_en) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                mem_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (w_live) begin
                mem_q[w_addr] <= w_data;
            end
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = r_addr[i*AW +: AW];
        assign hit  = (BYPASS != 0) && w_live && (w_addr == addr);

        always_comb begin
            r_data[i*XLEN +: XLEN] = mem_q[addr];
            r_busy[i]              = busy_q[addr];
            if (hit) begin
                r_data[i*XLEN +: XLEN] = w_data;
                r_busy[i]              = 1'b0;
            end
            if (addr == '0) begin
                r_data[i*XLEN +: XLEN] = '0;
                r_busy[i]              = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard: one bypassing and one non-bypassing instance
// share stimulus; each scenario task checks both against hand-computed values.
module tb_regfile_mp_scoreboard;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   r_addr;
    logic [NRD*XLEN-1:0] rd_b, rd_n;
    logic [NRD-1:0]      rb_b, rb_n;
    logic                w_en;
    logic [AW-1:0]       w_addr;
    logic [XLEN-1:0]     w_data;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;

    int n_tests;
    int n_fail;

    regfile_mp_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_dut_b (
        .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(rd_b), .r_busy(rb_b),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
    );

    regfile_mp_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_dut_n (
        .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(rd_n), .r_busy(rb_n),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst         = 1'b0;
        w_en        = 1'b0;
        w_addr      = '0;
        w_data      = '0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] a5;
        for (int a = 1; a < NREG; a++) begin
            a5          = AW'(a);
            w_en        = 1'b1;
            w_addr      = a5;
            w_data      = $urandom;
            sb_set_en   = 1'b1;
            sb_set_addr = a5;
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 0; a < NREG; a++) begin
            a5     = AW'(a);
            r_addr = {a5, a5};
            #1;
            n_tests++;
            if ({rd_b, rd_n} !== '0 || {rb_b, rb_n} !== '0) begin
                n_fail++;
                $display("FAIL reset_x%0d: data b=%h n=%h busy b=%b n=%b, required all zero",
                         a, rd_b, rd_n, rb_b, rb_n);
            end
        end
    endtask

    task automatic test_write();
        w_en   = 1'b1;
        w_addr = 5'd5;
        w_data = 32'hDEADBEEF;
        tick();
        w_en   = 1'b0;
        r_addr = {5'd5, 5'd5};
        #1;
        n_tests++;
        if ({rd_b, rd_n} !== {4{32'hDEADBEEF}}) begin
            n_fail++;
            $display("FAIL write_x5: data b=%h n=%h, required all DEADBEEF", rd_b, rd_n);
        end
        n_tests++;
        if ({rb_b, rb_n} !== 4'b0000) begin
            n_fail++;
            $display("FAIL write_x5_busy: busy b=%b n=%b, required 00", rb_b, rb_n);
        end
        w_en   = 1'b1;
        w_addr = 5'd0;
        w_data = 32'h1234;
        r_addr = {5'd0, 5'd0};
        #1;
        n_tests++;
        if ({rd_b, rd_n} !== '0) begin
            n_fail++;
            $display("FAIL write_x0_same_cycle: data b=%h n=%h, required 0", rd_b, rd_n);
        end
        tick();
        w_en = 1'b0;
        #1;
        n_tests++;
        if ({rd_b, rd_n} !== '0 || {rb_b, rb_n} !== '0) begin
            n_fail++;
            $display("FAIL write_x0: data b=%h n=%h busy b=%b n=%b, required 0",
                     rd_b, rd_n, rb_b, rb_n);
        end
    endtask

    task automatic test_bypass();
        // Claim x7 and write it in the same cycle: set wins, so x7 is busy with 11111111.
        w_en        = 1'b1;
        w_addr      = 5'd7;
        w_data      = 32'h11111111;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd7;
        tick();
        sb_set_en = 1'b0;
        w_data    = 32'hA5A5A5A5;
        r_addr    = {5'd5, 5'd7};
        #1;
        n_tests++;
        if (rd_b[31:0] !== 32'hA5A5A5A5 || rb_b[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_on: data=%h busy=%b, required A5A5A5A5 busy 0",
                     rd_b[31:0], rb_b[0]);
        end
        n_tests++;
        if (rd_n[31:0] !== 32'h11111111 || rb_n[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_off: data=%h busy=%b, required 11111111 busy 1",
                     rd_n[31:0], rb_n[0]);
        end
        n_tests++;
        if (rd_b[63:32] !== 32'hDEADBEEF || rd_n[63:32] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bypass_other_port: data b=%h n=%h, required DEADBEEF",
                     rd_b[63:32], rd_n[63:32]);
        end
        tick();
        w_en = 1'b0;
        #1;
        n_tests++;
        if ({rd_b[31:0], rd_n[31:0]} !== {2{32'hA5A5A5A5}} || {rb_b[0], rb_n[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL bypass_next: data b=%h n=%h busy b=%b n=%b, required A5A5A5A5 busy 0",
                     rd_b[31:0], rd_n[31:0], rb_b[0], rb_n[0]);
        end
    endtask

    task automatic test_scoreboard();
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd3;
        tick();
        sb_set_en = 1'b0;
        tick();
        tick();
        tick();
        r_addr = {5'd3, 5'd0};
        #1;
        n_tests++;
        if ({rb_b, rb_n} !== 4'b1010) begin
            n_fail++;
            $display("FAIL sb_busy_x3: busy b=%b n=%b, required 10 10", rb_b, rb_n);
        end
        // WAW re-claim keeps it busy.
        sb_set_en = 1'b1;
        tick();
        sb_set_en = 1'b0;
        w_en      = 1'b1;
        w_addr    = 5'd3;
        w_data    = 32'h33;
        #1;
        n_tests++;
        if (rb_b[1] !== 1'b0 || rd_b[63:32] !== 32'h33) begin
            n_fail++;
            $display("FAIL sb_wb_bypass: busy=%b data=%h, required 0 and 33", rb_b[1], rd_b[63:32]);
        end
        n_tests++;
        if (rb_n[1] !== 1'b1 || rd_n[63:32] !== 32'h0) begin
            n_fail++;
            $display("FAIL sb_wb_nobypass: busy=%b data=%h, required 1 and 0",
                     rb_n[1], rd_n[63:32]);
        end
        tick();
        w_en = 1'b0;
        #1;
        n_tests++;
        if ({rb_b[1], rb_n[1]} !== 2'b00 || {rd_b[63:32], rd_n[63:32]} !== {2{32'h33}}) begin
            n_fail++;
            $display("FAIL sb_wb_next: busy b=%b n=%b data b=%h n=%h, required 0 and 33",
                     rb_b[1], rb_n[1], rd_b[63:32], rd_n[63:32]);
        end
        // Writeback with no pending claim: harmless, still updates data.
        w_en   = 1'b1;
        w_data = 32'h44;
        tick();
        w_en = 1'b0;
        #1;
        n_tests++;
        if ({rb_b[1], rb_n[1]} !== 2'b00 || {rd_b[63:32], rd_n[63:32]} !== {2{32'h44}}) begin
            n_fail++;
            $display("FAIL sb_clear_idle: busy b=%b n=%b data b=%h n=%h, required 0 and 44",
                     rb_b[1], rb_n[1], rd_b[63:32], rd_n[63:32]);
        end
    endtask

    task automatic test_set_and_write();
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd9;
        w_en        = 1'b1;
        w_addr      = 5'd9;
        w_data      = 32'h55;
        tick();
        idle_inputs();
        r_addr = {5'd9, 5'd5};
        #1;
        n_tests++;
        if ({rd_b[63:32], rd_n[63:32]} !== {2{32'h55}} || {rb_b, rb_n} !== 4'b1010) begin
            n_fail++;
            $display("FAIL set_wins: data b=%h n=%h busy b=%b n=%b, required 55 busy 10 10",
                     rd_b[63:32], rd_n[63:32], rb_b, rb_n);
        end
        n_tests++;
        if ({rd_b[31:0], rd_n[31:0]} !== {2{32'hDEADBEEF}}) begin
            n_fail++;
            $display("FAIL multiport_x5: data b=%h n=%h, required DEADBEEF",
                     rd_b[31:0], rd_n[31:0]);
        end
    endtask

    task automatic test_reset_priority();
        rst         = 1'b1;
        w_en        = 1'b1;
        w_addr      = 5'd4;
        w_data      = 32'hFF;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd4;
        tick();
        idle_inputs();
        r_addr = {5'd9, 5'd4};
        #1;
        n_tests++;
        if ({rd_b, rd_n} !== '0 || {rb_b, rb_n} !== '0) begin
            n_fail++;
            $display("FAIL reset_priority: data b=%h n=%h busy b=%b n=%b, required all zero",
                     rd_b, rd_n, rb_b, rb_n);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        r_addr  = '0;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_set_and_write();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
